pad_cfg_sequencer: RTL
======================

Name: pad_cfg_sequencer

Overview:
Owns the per-pad configuration registers and output-enable gating that feed the pad frame.
Accepts one configuration-update request at a time over a valid/ready port.
Each update is applied glitch-safely:
- gate the pad's output enable off,
- wait a programmable settle time,
- write the new pad config and OE permission,
- respond.

Sits between the SoC control/peripheral logic and the pad frame's pad_cfg and io_oe inputs.

Parameters:
N_IO, 56, number of pads handled
NBIT_PADCFG, 6, config bits per pad; bit 0 = pull disable (pad PEN = ~cfg[0])
SETTLE_CYCLES, 4, cycles OE stays gated before the new config is applied; legal range 1..255

Ports:
clk_i  input  1  system clock
rst_ni  input  1  reset, asynchronous, active-low
req_valid_i  input  1  update request valid
req_ready_o  output  1  sequencer can accept a request
req_idx_i  input  IDX_W=$clog2(N_IO)  target pad index
req_cfg_i  input  NBIT_PADCFG  new pad config
req_oe_en_i  input  1  1 = pad output driving permitted after update
rsp_valid_o  output  1  one-cycle completion pulse
rsp_err_o  output  1  qualifies rsp_valid_o; 1 = request rejected
busy_o  output  1  sequence in progress (state != IDLE)
io_oe_i  input  N_IO  OE from the pad mux
io_oe_o  output  N_IO  gated OE to the pad frame = io_oe_i & oe_mask
pad_cfg_o  output  N_IO*NBIT_PADCFG  packed per-pad config, pad k at [k*NBIT_PADCFG +: NBIT_PADCFG]

Behaviour:
- Clock and reset: one clock (clk_i); reset rst_ni is asynchronous, active-low.
- Reset values: every pad_cfg entry = 0 (pull enabled); oe_mask = all 1; state IDLE; counter 0; req_ready_o=1; rsp_valid_o=0; rsp_err_o=0; busy_o=0.
- io_oe_o is combinational from io_oe_i and the registered mask. There is no other combinational input-to-output path.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - req_ready_o=1.
  - Request accepted at cycle T when req_valid_i & req_ready_o; idx, cfg and oe_en are latched.
  - Valid index (idx < N_IO): at the T edge, oe_mask[idx] <= 0, cnt <= SETTLE_CYCLES-1, next state SETTLE. The gated OE is visible at T+1.
  - Invalid index (idx >= N_IO): no register change; next state RESP with err=1; rsp_valid_o at T+1.
- SETTLE:
  - cnt decrements each cycle, so SETTLE lasts exactly SETTLE_CYCLES cycles (T+1 .. T+SETTLE_CYCLES).
  - On the edge where cnt==0: pad_cfg[idx] <= cfg, oe_mask[idx] <= oe_en, next state RESP with err=0.
- RESP:
  - rsp_valid_o=1 for exactly one cycle, at T+SETTLE_CYCLES+1; new config visible the same cycle.
  - Next state IDLE; req_ready_o=1 again at T+SETTLE_CYCLES+2.
- req_ready_o=0 in SETTLE and RESP. Requests presented then are held off, not dropped; the requester must hold valid and its payload stable until accepted.
- Rewriting an identical config still runs the full sequence; there is no shortcut.
- Only pad idx is touched. All other pads' cfg and mask are stable throughout.
- Reset asserted mid-sequence: everything returns to reset values immediately. The in-flight update is lost and no response is issued.
- The counter is 8 bits and never wraps: it is reloaded only on accept.

Optional Feature:
PAD_CFG_LOCK_EN
- Defined:
  - Adds a per-pad lock register (N_IO bits, reset 0), plus ports lock_set_i (1) and lock_idx_i (IDX_W).
  - A lock_set_i pulse with a valid index sets that pad's lock bit. The bit is sticky until reset.
  - A request to a locked pad is rejected exactly like an invalid index: RESP with err=1 at T+1, no mask/cfg change.
  - A lock set arriving during that pad's SETTLE does not abort the in-flight update.
- Undefined: no lock register or lock ports; behaviour as above.

Decomposition:
- Package pad_ctrl_pkg holds:
  - state enum {IDLE, SETTLE, RESP};
  - IDX_W derived from N_IO;
  - PADCFG_RST constant = '0;
  - settle counter width constant = 8.
- One natural sub-module: pad_settle_timer, a load/decrement/zero-flag down-counter.

Test Plan:
- Reset, then request idx=10, cfg=6'h01, oe_en=1, io_oe_i all 1, SETTLE_CYCLES=4 -> io_oe_o[10]=0 for T+1..T+4; pad_cfg[10]=6'h01 and io_oe_o[10]=1 at T+5; rsp_valid_o=1, err=0 at T+5; ready at T+6.
- Request idx=60 with N_IO=56 -> rsp_valid_o=1, rsp_err_o=1 at T+1; all cfg and io_oe_o unchanged.
- Request idx=3 with oe_en=0 -> io_oe_o[3] stays 0 after completion even with io_oe_i[3]=1.
- Back-to-back requests with valid held high -> second request accepted at T+6; both complete in order; no overlap of gated pads.
- rst_ni low at T+2 of a sequence on idx=20 -> pad_cfg[20]=0, oe_mask all 1, ready=1 asynchronously; no rsp_valid_o.
- With PAD_CFG_LOCK_EN: lock idx=5, then request idx=5 -> err=1 at T+1, cfg[5] unchanged; request idx=6 completes normally.

Source files
------------

// File: rtl/pad_ctrl_pkg.sv
// rtl/pad_ctrl_pkg.sv - shared types and constants for the pad configuration sequencer
package pad_ctrl_pkg;

  // Sequencer states: wait for a request, hold OE gated, issue the response
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int   PAD_N_IO   = 56;
  localparam int   PAD_IDX_W  = $clog2(PAD_N_IO);
  localparam logic PADCFG_RST = '0;
  localparam int   CNT_W      = 8;

endpackage

// File: rtl/pad_settle_timer.sv
// rtl/pad_settle_timer.sv - loadable settle down-counter with zero flag
module pad_settle_timer
  import pad_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // Reload on accept, otherwise count down and park at zero (never wraps)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pad_cfg_sequencer.sv
// rtl/pad_cfg_sequencer.sv - glitch-safe per-pad config/OE update sequencer (optional PAD_CFG_LOCK_EN)
module pad_cfg_sequencer
  import pad_ctrl_pkg::*;
#(
  parameter int  N_IO          = PAD_N_IO,
  parameter int  NBIT_PADCFG   = 6,
  parameter int  SETTLE_CYCLES = 4,
  localparam int IDX_W         = $clog2(N_IO)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [IDX_W-1:0]            req_idx_i,
  input  logic [NBIT_PADCFG-1:0]      req_cfg_i,
  input  logic                        req_oe_en_i,
  output logic                        rsp_valid_o,
  output logic                        rsp_err_o,
  output logic                        busy_o,
`ifdef PAD_CFG_LOCK_EN
  input  logic                        lock_set_i,
  input  logic [IDX_W-1:0]            lock_idx_i,
`endif
  input  logic [N_IO-1:0]             io_oe_i,
  output logic [N_IO-1:0]             io_oe_o,
  output logic [N_IO*NBIT_PADCFG-1:0] pad_cfg_o
);

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q;
  logic [NBIT_PADCFG-1:0]     cfg_q;
  logic                       oe_en_q;
  logic                       err_q;
  logic [N_IO-1:0]            oe_mask_q;
  logic [N_IO*NBIT_PADCFG-1:0] pad_cfg_q;
  logic [CNT_W-1:0]           cnt;
  logic                       cnt_zero;
  logic                       accept;
  logic                       idx_ok;
  logic                       reject;
  logic                       apply;

  assign idx_ok = (32'(req_idx_i) < 32'(N_IO));
  assign accept = req_valid_i && (state_q == IDLE);
  assign apply  = (state_q == SETTLE) && cnt_zero;

`ifdef PAD_CFG_LOCK_EN
  logic [N_IO-1:0] lock_q;
  logic            lock_idx_ok;

  assign lock_idx_ok = (32'(lock_idx_i) < 32'(N_IO));
  // A locked pad is refused just like an out-of-range one
  assign reject      = !idx_ok || lock_q[req_idx_i];

  // Sticky lock bits; only reset clears them
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= '0;
    end else if (lock_set_i && lock_idx_ok) begin
      lock_q[lock_idx_i] <= 1'b1;
    end
  end
`else
  assign reject = !idx_ok;
`endif

  pad_settle_timer u_timer (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .load     (accept && !reject),
    .load_val (CNT_W'(SETTLE_CYCLES - 1)),
    .dec      (state_q == SETTLE),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = reject ? RESP : SETTLE;
      SETTLE:  if (cnt_zero) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_err_o   = 1'b0;
    busy_o      = 1'b1;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
      end
      default: ;
    endcase
  end

  // Request latch, OE gating on accept and config/OE commit when settle expires
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q     <= '0;
      cfg_q     <= '0;
      oe_en_q   <= 1'b0;
      err_q     <= 1'b0;
      oe_mask_q <= '1;
      pad_cfg_q <= {(N_IO*NBIT_PADCFG){PADCFG_RST}};
    end else begin
      if (accept) begin
        idx_q   <= req_idx_i;
        cfg_q   <= req_cfg_i;
        oe_en_q <= req_oe_en_i;
        err_q   <= reject;
        if (!reject) begin
          oe_mask_q[req_idx_i] <= 1'b0;
        end
      end
      if (apply) begin
        oe_mask_q[idx_q] <= oe_en_q;
        pad_cfg_q[int'(idx_q)*NBIT_PADCFG +: NBIT_PADCFG] <= cfg_q;
      end
    end
  end

  assign io_oe_o   = io_oe_i & oe_mask_q;
  assign pad_cfg_o = pad_cfg_q;

endmodule
